// File: rtl/multi_lane_phrase_gen.sv
// rtl/multi_lane_phrase_gen.sv - odometer candidate generator feeding a round-robin pool of hash lanes
// Issues every charset string of length L once, tracks per-lane in-flight work, flags the lane whose digest matches.
module multi_lane_phrase_gen #(
  parameter int LANES    = 4,
  parameter int MAX_LEN  = 8,
  parameter int CS_DEPTH = 64,
  parameter int HASH_W   = 128,
  localparam int CW = $clog2(CS_DEPTH),
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cs_we,
  input  logic [CW-1:0]             cs_addr,
  input  logic [7:0]                cs_data,
  input  logic [CW:0]               prg_num_chars,
  input  logic [7:0]                prg_len,
  input  logic [HASH_W-1:0]         prg_goal,
  input  logic                      start,
  input  logic                      abort,
  output logic [8*MAX_LEN-1:0]      m,
  output logic [63:0]               m_len,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [LW-1:0]             m_lane,
  input  logic [LANES-1:0]          res_valid,
  input  logic [LANES*HASH_W-1:0]   res_hash,
  output logic                      found,
  output logic                      exhausted,
  output logic                      busy,
  output logic [8*MAX_LEN-1:0]      found_msg,
  output logic [LW-1:0]             found_lane,
  output logic [2:0]                state
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_RUN = 3'd1, S_DRAIN = 3'd2, S_FOUND = 3'd3, S_EXHAUST = 3'd4
  } state_t;

  state_t cur, nxt;

  logic [7:0]           cs_mem [CS_DEPTH];
  logic [CW:0]          num_r;
  logic [7:0]           len_r;
  logic [HASH_W-1:0]    goal_r;
  logic [CW-1:0]        digits     [MAX_LEN];
  logic [CW-1:0]        digits_nxt [MAX_LEN];
  logic [8*MAX_LEN-1:0] hold       [LANES];
  logic [8*MAX_LEN-1:0] cand;
  logic [LANES-1:0]     lane_busy, hit_r;
  logic [LW-1:0]        ptr, sel, hit_idx, lane_hold;
  logic                 sel_ok, lane_hold_v, hit_any, active, idle_like, hs, wrap_out, carry;
  int                   j;

  assign active    = (cur == S_RUN) || (cur == S_DRAIN);
  assign idle_like = (cur == S_IDLE) || (cur == S_FOUND) || (cur == S_EXHAUST);
  assign busy      = active;
  assign state     = cur;
  assign hit_any   = |hit_r;
  assign m_len     = {53'd0, len_r, 3'd0};
  // A pending match blocks issue so the matching lane's holding register cannot be reused
  assign m_valid   = (cur == S_RUN) && sel_ok && !hit_any;
  assign m_lane    = lane_hold_v ? lane_hold : sel;
  assign m         = (cur == S_RUN) ? cand : '0;
  assign hs        = m_valid && m_ready;

  always_comb begin
    cand = '0;
    for (int i = 0; i < MAX_LEN; i++)
      if (8'(i) < len_r) cand[8*i +: 8] = cs_mem[digits[i]];
  end

  always_comb begin
    carry = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      digits_nxt[i] = digits[i];
      if ((8'(i) < len_r) && carry) begin
        if ({1'b0, digits[i]} == num_r - (CW+1)'(1)) digits_nxt[i] = '0;
        else begin
          digits_nxt[i] = digits[i] + CW'(1);
          carry = 1'b0;
        end
      end
    end
    wrap_out = carry;
  end

  always_comb begin
    sel_ok = 1'b0;
    sel    = '0;
    j      = 0;
    for (int i = LANES-1; i >= 0; i--) begin
      j = (int'(ptr) + i) % LANES;
      if (!lane_busy[j]) begin
        sel_ok = 1'b1;
        sel    = LW'(j);
      end
    end
  end

  always_comb begin
    hit_idx = '0;
    for (int k = LANES-1; k >= 0; k--)
      if (hit_r[k]) hit_idx = LW'(k);
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE, S_FOUND, S_EXHAUST: if (start) nxt = S_RUN;
      S_RUN: begin
        if (hit_any) nxt = S_FOUND;
        else if (hs && wrap_out) nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (hit_any) nxt = S_FOUND;
        else if (lane_busy == '0) nxt = S_EXHAUST;
      end
      default: nxt = S_IDLE;
    endcase
    if (abort) nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) cur <= S_IDLE;
    else     cur <= nxt;
  end

  always_ff @(posedge clk) begin
    if (cs_we && !busy) cs_mem[cs_addr] <= cs_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_r <= '0; len_r <= '0; goal_r <= '0;
      for (int i = 0; i < MAX_LEN; i++) digits[i] <= '0;
      lane_busy <= '0; hit_r <= '0; ptr <= '0;
      lane_hold_v <= 1'b0; lane_hold <= '0;
      found <= 1'b0; exhausted <= 1'b0; found_msg <= '0; found_lane <= '0;
    end else if (abort) begin
      lane_busy <= '0; hit_r <= '0; lane_hold_v <= 1'b0;
      found <= 1'b0; exhausted <= 1'b0;
    end else if (start && idle_like) begin
      num_r <= prg_num_chars; len_r <= prg_len; goal_r <= prg_goal;
      for (int i = 0; i < MAX_LEN; i++) digits[i] <= '0;
      lane_busy <= '0; hit_r <= '0; ptr <= '0; lane_hold_v <= 1'b0;
      found <= 1'b0; exhausted <= 1'b0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (active && res_valid[k] && lane_busy[k]) begin
          lane_busy[k] <= 1'b0;
          hit_r[k]     <= (res_hash[k*HASH_W +: HASH_W] == goal_r);
        end else begin
          hit_r[k] <= 1'b0;
          if (hs && (m_lane == LW'(k))) lane_busy[k] <= 1'b1;
        end
      end
      if (hs) begin
        for (int i = 0; i < MAX_LEN; i++) digits[i] <= digits_nxt[i];
        ptr          <= (m_lane == LW'(LANES-1)) ? '0 : m_lane + LW'(1);
        hold[m_lane] <= m;
      end
      // Remember an offered-but-stalled lane so a lane freeing up ahead of it cannot steal the slot
      lane_hold_v <= m_valid && !m_ready;
      lane_hold   <= m_lane;
      if (active && hit_any) begin
        found      <= 1'b1;
        found_msg  <= hold[hit_idx];
        found_lane <= hit_idx;
        lane_busy  <= '0;
      end
      if ((cur == S_DRAIN) && !hit_any && (lane_busy == '0)) exhausted <= 1'b1;
    end
  end
endmodule
